// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Holds the PC, issues in-order word
//               requests to instruction memory under a credit limit, buffers
//               returned words with their PCs in a small FIFO and hands them to
//               decode over valid/ready. Redirects flush buffered and in-flight
//               instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(FIFO_DEPTH);

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_drop_cnt;
    logic [c_CW-1:0] r_count;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [31:0]     r_mem_pc   [FIFO_DEPTH];
    logic [31:0]     r_mem_inst [FIFO_DEPTH];

    logic [c_CW:0]   w_credit;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_head_valid;
    logic            w_id_valid;
    logic            w_pop;
    logic            w_drop;
    logic            w_push;
    logic [31:0]     w_redirect_pc;
    logic            w_unused;

    // Request credit: in-flight plus buffered may never exceed the FIFO size,
    // so every kept response is guaranteed a free slot.
    assign w_credit      = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req_valid   = !rst && !redirect_valid && (w_credit < c_DEPTH);
    assign w_req_fire    = w_req_valid && imem_req_ready;
    assign w_head_valid  = !rst && (r_count != '0);
    assign w_id_valid    = w_head_valid && !redirect_valid;
    assign w_pop         = w_id_valid && id_ready;
    assign w_drop        = (r_drop_cnt != '0);
    assign w_push        = imem_rsp_valid && !redirect_valid && !w_drop;
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused      = ^redirect_pc[1:0];

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign id_valid       = w_id_valid;
    assign id_inst        = w_head_valid ? r_mem_inst[r_rd_ptr] : 32'h0;
    assign id_pc          = w_head_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;

    // Control state: PCs, in-flight/drop counters, FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_CW'(w_req_fire) - c_CW'(imem_rsp_valid);
            if (redirect_valid) begin
                // Everything still in flight after this cycle's response is stale.
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_drop_cnt <= r_outstanding - c_CW'(imem_rsp_valid);
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (imem_rsp_valid) begin
                    if (w_drop) begin
                        r_drop_cnt <= r_drop_cnt - c_CW'(1);
                    end else begin
                        r_rsp_pc <= r_rsp_pc + 32'd4;
                        r_wr_ptr <= r_wr_ptr + c_AW'(1);
                    end
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CW'(1);
                    2'b01:   r_count <= r_count - c_CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage: write the kept response with the PC it belongs to.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
            r_mem_inst[r_wr_ptr] <= imem_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core. It holds the PC, issues in-order word requests to instruction memory, buffers returned instructions with their PCs in a small FIFO, and presents them to the decode stage (decoder plus immediate generator) over a valid/ready handshake. Branch and jump redirects from execute flush all buffered and in-flight instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word address (bits [1:0] always 00)
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after acceptance, no backpressure
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch (taken branch, jal, jalr)
- redirect_pc  in  32  new PC; bits [1:0] ignored, treated as 00
- id_valid  out  1  id_inst/id_pc valid to decode
- id_ready  in  1  decode accepts this cycle
- id_inst  out  32  instruction word at FIFO head; 0 when FIFO empty
- id_pc  out  32  PC of id_inst; 0 when FIFO empty

## Operation
- State: fetch_pc (next request address), rsp_pc (PC of next kept response), outstanding (accepted, not yet answered; 0..FIFO_DEPTH), drop_cnt (responses still to discard), FIFO of {pc, inst}, count.
- Request: imem_req_valid = !rst && !redirect_valid && (outstanding + count < FIFO_DEPTH), using registered values. imem_req_addr = fetch_pc. On accept: fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
- Response: outstanding -= 1. If drop_cnt > 0: discard, drop_cnt -= 1. Otherwise push {rsp_pc, imem_rsp_data}; rsp_pc += 4.
- Credit rule guarantees a kept response never finds the FIFO full; a push into a full FIFO is a design error (assertion in bench).
- Decode: id_valid = (count != 0) && !redirect_valid. Pop when id_valid && id_ready. Push and pop in the same cycle keep count unchanged.
- Redirect (redirect_valid=1): FIFO emptied; fetch_pc and rsp_pc ← {redirect_pc[31:2], 2'b00}; no request issued and no pop this cycle; a response arriving this cycle is discarded; drop_cnt ← outstanding − imem_rsp_valid (drops every request in flight); outstanding updated normally. Back-to-back redirects: last one wins, drop_cnt recomputed each time.
- No instruction decoding here; illegal or compressed encodings pass through untouched.

## Timing
- Reset values: fetch_pc = rsp_pc = RESET_PC, FIFO empty, outstanding = drop_cnt = 0; during rst: imem_req_valid = 0, id_valid = 0, id_inst = id_pc = 0. Instruction memory shares rst; no responses arrive for pre-reset requests.
- First request in the first cycle after rst deasserts, address RESET_PC.
- Response in cycle N → id_valid in cycle N+1 (FIFO write, no bypass).
- Redirect in cycle N → first request with the new PC in cycle N+1 (if memory ready); id_valid low in N and until the first new response has been buffered.
- With a 1-cycle memory and id_ready held high, FIFO_DEPTH=4 sustains one instruction per cycle.
- Reset mid-operation clears all state in that cycle regardless of other inputs.

## Test plan
- Reset then stream: 1-cycle memory, id_ready=1 → requests at 0x0, 0x4, 0x8…, one instruction per cycle to decode, id_pc matching, first id_valid 2 cycles after first request.
- Decode stall: id_ready=0 for 10 cycles → at most 4 requests outstanding+buffered, imem_req_valid drops, no lost or duplicated instruction after id_ready returns.
- Redirect with 2 in flight: redirect_pc=0x100 while outstanding=2 → both stale responses dropped, next id_pc = 0x100 with correct inst, FIFO contents before redirect never shown.
- Redirect coinciding with response and with id_ready=1 → no handshake that cycle, response discarded, fetch resumes at redirect_pc next cycle.
- Memory backpressure: imem_req_ready random 50% and variable response latency 1–5 cycles → in-order stream, imem_req_addr stable while valid and not ready.
- Edge cases: redirect_pc=0x203 → fetch at 0x200; fetch_pc from 0xFFFF_FFFC wraps to 0x0; rst asserted mid-stream → all outputs return to reset values next cycle and fetch restarts at RESET_PC.
